// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
// Purpose: fetch FSM state encoding, default PC parameters and the nop word.
// Ports: none (package).

package ifu_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } ifu_state_e;

  localparam logic [31:0] PC_BASE_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/ifu_pc_reg.sv
// rtl/ifu_pc_reg.sv - zero-based program counter register
// Purpose: holds the internal PC; a flush load beats a next-PC load.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush_ld     load flush_pc
//   flush_pc     restart PC
//   npc_ld       load npc_in
//   npc_in       next PC from the next-PC logic
//   pc_q         current internal PC

module ifu_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_ld,
  input  logic [31:0] flush_pc,
  input  logic        npc_ld,
  input  logic [31:0] npc_in,
  output logic [31:0] pc_q
);

  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (flush_ld) begin
      pc_d = flush_pc;
    end else if (npc_ld) begin
      pc_d = npc_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-outstanding instruction fetch stage
// Purpose: owns the PC, issues one imem request at a time, holds the fetched
//   instruction for decode and loads the next PC on accept. Flush restarts at
//   flush_pc and drops any response still in flight.
// Build option: IFU_ALIGN_CHECK_EN - a misaligned PC produces a nop with
//   fetch_fault set instead of a memory request.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   npc_in                             next internal PC (valid while if_valid)
//   flush, flush_pc                    restart request and restart PC
//   imem_req, imem_addr, imem_gnt      request channel
//   imem_rvalid, imem_rdata            response channel
//   if_valid, if_instr, if_pc          held instruction and its internal PC
//   if_pc_disp                         if_pc + PC_BASE
//   id_ready                           decode accepts the held instruction
//   fetch_fault                        misalignment fault (0 when compiled out)

module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] PC_BASE  = PC_BASE_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc_in,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_disp,
  input  logic        id_ready,
  output logic        fetch_fault
);

  ifu_state_e  state_q, state_d;
  logic        kill_q, kill_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] pc_q;
  logic        flush_ld;
  logic        npc_ld;
  logic        misalign;

`ifdef IFU_ALIGN_CHECK_EN
  logic        fault_q, fault_d;
  assign misalign    = (pc_q[1:0] != 2'b00);
  assign fetch_fault = fault_q;
`else
  assign misalign    = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  ifu_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_ld (flush_ld),
    .flush_pc (flush_pc),
    .npc_ld   (npc_ld),
    .npc_in   (npc_in),
    .pc_q     (pc_q)
  );

  // Gated with rst_n so no request is seen while reset is asserted.
  assign imem_req   = rst_n && (state_q == ISSUE) && !misalign;
  assign imem_addr  = pc_q;
  assign if_valid   = valid_q;
  assign if_instr   = instr_q;
  assign if_pc      = ifpc_q;
  assign if_pc_disp = ifpc_q + PC_BASE;

  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;
    flush_ld = 1'b0;
    npc_ld   = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    fault_d  = fault_q;
`endif
    if (flush) begin
      flush_ld = 1'b1;
      valid_d  = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      fault_d  = 1'b0;
`endif
    end
    unique case (state_q)
      ISSUE: begin
        if (flush) begin
          // A request granted in the flush cycle is already in flight.
          if (imem_req && imem_gnt) begin
            kill_d  = 1'b1;
            state_d = WAIT;
          end
        end else if (misalign) begin
          valid_d = 1'b1;
          instr_d = NOP_INSTR;
          ifpc_d  = pc_q;
`ifdef IFU_ALIGN_CHECK_EN
          fault_d = 1'b1;
`endif
          state_d = HOLD;
        end else if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          // A response arriving with the flush is the in-flight one: drop it
          // now rather than waiting for a response that will never come.
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            ifpc_d  = pc_q;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = ISSUE;
        end else if (id_ready) begin
          npc_ld  = 1'b1;
          valid_d = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
          fault_d = 1'b0;
`endif
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ISSUE;
      kill_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`endif

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Fetch stage sitting directly upstream of the next-PC logic.
- Owns the PC register and issues one instruction-memory request at a time.
- Presents the fetched instruction and its PC to decode and the next-PC logic, then loads the next-PC result when decode accepts the instruction.
- PC is held zero-based internally; PC_BASE is added only on the display/link output.

Parameters:
- PC_BASE, 32'h0000_3000, offset added to the internal PC for pc_disp.
- RESET_PC, 32'h0000_0000, internal PC value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- npc_in  input  32  next internal PC from the next-PC logic, valid while if_valid.
- flush  input  1  discard the current instruction and any in-flight fetch; restart at flush_pc.
- flush_pc  input  32  internal restart PC.
- imem_req  output  1  fetch request.
- imem_addr  output  32  internal byte address, equal to pc_q.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response valid, at least 1 cycle after gnt.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  if_instr/if_pc valid.
- if_instr  output  32  held instruction.
- if_pc  output  32  internal PC of if_instr (feeds next-PC PC input).
- if_pc_disp  output  32  if_pc + PC_BASE (link value, debug).
- id_ready  input  1  decode accepts the instruction this cycle.
- fetch_fault  output  1  optional-feature fault flag; constant 0 when the feature is compiled out.

Behaviour:
- Reset (asynchronous, rst_n low):
  - pc_q = RESET_PC; state = ISSUE.
  - if_valid = 0, if_instr = 0, fetch_fault = 0, kill = 0.
  - imem_req = 0 while in reset. imem_req is combinational on state == ISSUE, so it asserts from the first edge after release.
- States:
  - ISSUE: imem_req = 1, imem_addr = pc_q. On imem_gnt go to WAIT; otherwise stay (req and addr held stable).
  - WAIT: on imem_rvalid, capture if_instr = imem_rdata, if_pc = pc_q, set if_valid and go to HOLD.
  - HOLD: if_valid = 1, outputs stable. On id_ready: pc_q = npc_in, if_valid = 0, go to ISSUE.
- Latency: gnt in the same cycle as req and rvalid one cycle later gives 3 cycles per instruction (ISSUE, WAIT, HOLD with id_ready high).
- One outstanding request maximum. No speculation; the next PC comes only from npc_in.
- flush, highest priority, in any state:
  - pc_q = flush_pc; if_valid = 0.
  - In WAIT: set kill and stay in WAIT. The next rvalid is dropped and clears kill; the FSM then goes to ISSUE. Otherwise go to ISSUE.
  - In ISSUE with gnt in the same cycle: the granted request is treated as in-flight, so kill = 1 and state = WAIT.
  - flush together with id_ready: flush wins, npc_in is ignored.
  - flush while kill is already set: pc_q updates, kill stays 1.
- rvalid outside WAIT: ignored.
- Arithmetic: if_pc_disp = if_pc + PC_BASE, modulo 2^32, combinational. pc_q wraps naturally.
- Reset mid-WAIT: the pending response after reset release is not tracked. The memory must also be reset by rst_n.

Optional Feature:
- Macro: IFU_ALIGN_CHECK_EN.
- Defined:
  - On entering ISSUE with pc_q[1:0] != 0, no request is issued.
  - if_valid = 1, if_instr = 32'h0000_0000 (nop), fetch_fault = 1 for that instruction. fetch_fault is cleared on accept or flush.
- Undefined:
  - fetch_fault is tied 0.
  - Address bits [1:0] are passed to memory unchanged.

Decomposition:
- ifu_pkg holds:
  - State enum: ISSUE, WAIT, HOLD.
  - Constants PC_BASE_DEFAULT and RESET_PC_DEFAULT.
  - NOP_INSTR = 32'h0000_0000.
- One natural sub-module, ifu_pc_reg: PC register with async active-low reset. Load priority is flush_pc, then npc_in, then hold.

Test Plan:
- Reset release, gnt tied 1, rvalid 1 cycle later with rdata 32'h3c01_1234:
  - imem_addr = 0.
  - if_valid high on the 3rd cycle after release, if_pc = 0, if_pc_disp = 32'h0000_3000.
- id_ready high, npc_in = if_pc + 4 each time: addresses 0, 4, 8 in sequence, one instruction every 3 cycles.
- id_ready held low 5 cycles in HOLD:
  - if_instr and if_pc stable, imem_req = 0.
  - On id_ready, pc_q = npc_in = 32'h0000_0040 and the next request uses that address.
- gnt delayed 4 cycles: imem_req and imem_addr stay stable; no second request.
- flush with flush_pc = 32'h0000_0100 during WAIT:
  - The next rvalid's data never appears on if_instr.
  - The following request addresses 32'h0000_0100.
- flush and id_ready together in HOLD with npc_in = 8, flush_pc = 32'h0000_0080: next request addresses 32'h0000_0080.
- With IFU_ALIGN_CHECK_EN, flush_pc = 32'h0000_0102: no imem_req; if_valid = 1, fetch_fault = 1, if_instr = 0.
